hack_memory: RTL and testbench

HACK_MEMORY -- requirements
Module: hack_memory

---
 rtl/hack_pkg.sv | 32 +++
 rtl/sync_ram_dp.sv | 37 +++
 rtl/hack_memory.sv | 100 ++++++++++
 tb/tb_hack_memory.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared Hack memory-map constants, region type and address decode.
package hack_pkg;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned VID_AW = 13;

    localparam logic [ADDR_W-1:0] RAM_BASE    = 15'h0000;
    localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;
    localparam logic [ADDR_W-1:0] KBD_ADDR    = 15'h6000;

    typedef enum logic [1:0] {
        RAM      = 2'd0,
        SCREEN   = 2'd1,
        KBD      = 2'd2,
        UNMAPPED = 2'd3
    } region_t;

    function automatic region_t decode_region(input logic [ADDR_W-1:0] addr);
        region_t r;
        if (addr < SCREEN_BASE)
            r = RAM;
        else if (addr < KBD_ADDR)
            r = SCREEN;
        else if (addr == KBD_ADDR)
            r = KBD;
        else
            r = UNMAPPED;
        return r;
    endfunction

endpackage

// File: rtl/sync_ram_dp.sv
// Dual-port synchronous RAM: port A read/write, port B read-only, both read-first
// with one-cycle registered read data. Reset clears read registers, never the array.
module sync_ram_dp #(
    parameter int unsigned DEPTH = 16384,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk2x,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic [WIDTH-1:0] a_rdata,
    input  logic [AW-1:0]    b_addr,
    output logic [WIDTH-1:0] b_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array write; suppressed while reset is high so the reset-edge write is lost.
    always_ff @(posedge clk2x) begin
        if (!reset && we)
            mem[a_addr] <= a_wdata;
    end

    // Both reads sample the array before the same-edge write lands (read-first).
    always_ff @(posedge clk2x) begin
        if (reset) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            a_rdata <= mem[a_addr];
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/hack_memory.sv
// Hack data memory: RAM, screen buffer with scan-out port, keyboard register,
// and a sticky flag for writes that land on read-only or unmapped addresses.
module hack_memory
    import hack_pkg::*;
#(
    parameter int unsigned RAM_WORDS    = 16384,
    parameter int unsigned SCREEN_WORDS = 8192
) (
    input  logic              clk2x,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addressM,
    input  logic [DATA_W-1:0] outM,
    input  logic              writeM,
    output logic [DATA_W-1:0] inM,
    input  logic              kbd_valid,
    input  logic [DATA_W-1:0] kbd_code,
    output logic              kbd_ready,
    input  logic [VID_AW-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              bad_write
);

    localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned SCR_AW = (SCREEN_WORDS > 1) ? $clog2(SCREEN_WORDS) : 1;

    region_t           region_c;
    region_t           sel_q;
    logic [DATA_W-1:0] kbd_reg;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] scr_rdata;
    logic [DATA_W-1:0] ram_b_unused;
    logic [RAM_AW-1:0] ram_off;
    logic [SCR_AW-1:0] scr_off;
    logic              ram_we;
    logic              scr_we;

    assign region_c = decode_region(addressM);
    assign ram_off  = RAM_AW'(addressM - RAM_BASE);
    assign scr_off  = SCR_AW'(addressM - SCREEN_BASE);
    assign ram_we   = writeM && (region_c == RAM);
    assign scr_we   = writeM && (region_c == SCREEN);

    // The keyboard register can always take an offer outside reset.
    assign kbd_ready = ~reset;

    sync_ram_dp #(
        .DEPTH (RAM_WORDS),
        .WIDTH (DATA_W)
    ) u_ram (
        .clk2x   (clk2x),
        .reset   (reset),
        .we      (ram_we),
        .a_addr  (ram_off),
        .a_wdata (outM),
        .a_rdata (ram_rdata),
        .b_addr  ('0),
        .b_rdata (ram_b_unused)
    );

    sync_ram_dp #(
        .DEPTH (SCREEN_WORDS),
        .WIDTH (DATA_W)
    ) u_screen (
        .clk2x   (clk2x),
        .reset   (reset),
        .we      (scr_we),
        .a_addr  (scr_off),
        .a_wdata (outM),
        .a_rdata (scr_rdata),
        .b_addr  (SCR_AW'(vid_addr)),
        .b_rdata (vid_data)
    );

    // Registered read select, keyboard register and sticky bad-write flag.
    always_ff @(posedge clk2x) begin
        if (reset) begin
            sel_q     <= UNMAPPED;
            kbd_reg   <= '0;
            bad_write <= 1'b0;
        end else begin
            sel_q <= region_c;
            if (kbd_valid)
                kbd_reg <= kbd_code;
            if (writeM && (region_c == KBD || region_c == UNMAPPED))
                bad_write <= 1'b1;
        end
    end

    // Selecting the live keyboard register makes a same-edge load visible (write-first).
    always_comb begin
        inM = '0;
        unique case (sel_q)
            RAM:      inM = ram_rdata;
            SCREEN:   inM = scr_rdata;
            KBD:      inM = kbd_reg;
            default:  inM = '0;
        endcase
    end

endmodule

// File: tb/tb_hack_memory.sv
// Directed vector table plus randomized traffic against a map-based memory model.
module tb_hack_memory;

    logic        clk2x = 1'b0;
    logic        reset;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic        kbd_valid;
    logic [15:0] kbd_code;
    logic        kbd_ready;
    logic [12:0] vid_addr;
    logic [15:0] vid_data;
    logic        bad_write;

    hack_memory dut (
        .clk2x     (clk2x),
        .reset     (reset),
        .addressM  (addressM),
        .outM      (outM),
        .writeM    (writeM),
        .inM       (inM),
        .kbd_valid (kbd_valid),
        .kbd_code  (kbd_code),
        .kbd_ready (kbd_ready),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .bad_write (bad_write)
    );

    always #5 clk2x = ~clk2x;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: sparse memories keyed by region offset.
    logic [15:0] m_ram [int];
    logic [15:0] m_scr [int];
    logic [15:0] m_kbd = 16'h0;
    logic        m_bad = 1'b0;
    logic [15:0] e_inm, e_vid;
    logic        e_inm_known, e_vid_known;

    typedef struct {
        logic        rst;
        logic [14:0] addr;
        logic [15:0] data;
        logic        we;
        logic        kv;
        logic [15:0] kc;
        logic [12:0] va;
        logic        ci;
        logic [15:0] ei;
        logic        cv;
        logic [15:0] ev;
        logic        eb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge using the inputs currently applied.
    task automatic model_edge();
        int a;
        a = int'(addressM);
        if (reset) begin
            e_inm = 16'h0; e_inm_known = 1'b1;
            e_vid = 16'h0; e_vid_known = 1'b1;
            m_kbd = 16'h0; m_bad = 1'b0;
            return;
        end
        e_vid_known = m_scr.exists(int'(vid_addr));
        e_vid       = e_vid_known ? m_scr[int'(vid_addr)] : 16'h0;
        if (kbd_valid) m_kbd = kbd_code;
        if (a < 'h4000) begin
            e_inm_known = m_ram.exists(a);
            e_inm       = e_inm_known ? m_ram[a] : 16'h0;
            if (writeM) m_ram[a] = outM;
        end else if (a < 'h6000) begin
            e_inm_known = m_scr.exists(a - 'h4000);
            e_inm       = e_inm_known ? m_scr[a - 'h4000] : 16'h0;
            if (writeM) m_scr[a - 'h4000] = outM;
        end else begin
            e_inm_known = 1'b1;
            e_inm       = (a == 'h6000) ? m_kbd : 16'h0;
            if (writeM) m_bad = 1'b1;
        end
    endtask

    task automatic drive(input logic rst, input logic [14:0] addr, input logic [15:0] data,
                         input logic we, input logic kv, input logic [15:0] kc, input logic [12:0] va);
        reset = rst; addressM = addr; outM = data; writeM = we;
        kbd_valid = kv; kbd_code = kc; vid_addr = va;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk2x);
        #1;
    endtask

    initial begin
        drive(1'b1, 15'h0, 16'h0, 1'b0, 1'b0, 16'h0, 13'h0);

        //             rst  addr     data      we   kv   kc        va        ci   ei        cv   ev        eb
        vecs.push_back(vec_t'{1'b1, 15'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h0005, 16'h1234, 1'b1, 1'b0, 16'h0000, 13'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h0005, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h4000, 16'h0F0F, 1'b1, 1'b0, 16'h0000, 13'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h4000, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'h0F0F, 1'b1, 16'h0F0F, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h4000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h6000, 16'h0000, 1'b0, 1'b1, 16'h0041, 13'h0000, 1'b1, 16'h0041, 1'b1, 16'hFFFF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h6000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'h0041, 1'b1, 16'hFFFF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h6000, 16'h0000, 1'b0, 1'b1, 16'h0000, 13'h0000, 1'b1, 16'h0000, 1'b1, 16'hFFFF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h0005, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'h1234, 1'b1, 16'hFFFF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h6000, 16'h0000, 1'b0, 1'b1, 16'h0055, 13'h0000, 1'b1, 16'h0055, 1'b1, 16'hFFFF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h6000, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'h0055, 1'b1, 16'hFFFF, 1'b1});
        vecs.push_back(vec_t'{1'b0, 15'h7000, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'h0000, 1'b1, 16'hFFFF, 1'b1});
        vecs.push_back(vec_t'{1'b0, 15'h6000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'h0055, 1'b1, 16'hFFFF, 1'b1});
        vecs.push_back(vec_t'{1'b0, 15'h7000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'h0000, 1'b1, 16'hFFFF, 1'b1});
        vecs.push_back(vec_t'{1'b0, 15'h0010, 16'h0001, 1'b1, 1'b0, 16'h0000, 13'h0000, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b1});
        vecs.push_back(vec_t'{1'b0, 15'h0010, 16'h0002, 1'b1, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'h0001, 1'b1, 16'hFFFF, 1'b1});
        vecs.push_back(vec_t'{1'b0, 15'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'h0002, 1'b1, 16'hFFFF, 1'b1});
        vecs.push_back(vec_t'{1'b0, 15'h0003, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 13'h0000, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b1});
        vecs.push_back(vec_t'{1'b1, 15'h0003, 16'h5555, 1'b1, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h0003, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'hAAAA, 1'b1, 16'hFFFF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h6000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'h0000, 1'b1, 16'hFFFF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h5FFF, 16'h1357, 1'b1, 1'b0, 16'h0000, 13'h1FFF, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h5FFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'h1FFF, 1'b1, 16'h1357, 1'b1, 16'h1357, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h3FFF, 16'h2468, 1'b1, 1'b0, 16'h0000, 13'h0000, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h3FFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'h2468, 1'b1, 16'hFFFF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h4000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 15'h6001, 16'h1111, 1'b1, 1'b0, 16'h0000, 13'h0000, 1'b1, 16'h0000, 1'b1, 16'hFFFF, 1'b1});

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].addr, vecs[i].data, vecs[i].we,
                  vecs[i].kv, vecs[i].kc, vecs[i].va);
            step();
            if (vecs[i].ci) check($sformatf("vec%0d inM", i), inM, vecs[i].ei);
            if (vecs[i].cv) check($sformatf("vec%0d vid_data", i), vid_data, vecs[i].ev);
            check($sformatf("vec%0d bad_write", i), 16'(bad_write), 16'(vecs[i].eb));
            check($sformatf("vec%0d kbd_ready", i), 16'(kbd_ready), 16'(!vecs[i].rst));
        end

        // Two-cycle reset with a key offered and a screen write pending: both are dropped.
        drive(1'b0, 15'h6000, 16'h0000, 1'b0, 1'b1, 16'h0077, 13'h0000);
        step();
        check("pre-reset kbd load", inM, 16'h0077);
        drive(1'b1, 15'h4000, 16'h1111, 1'b1, 1'b1, 16'h0099, 13'h0000);
        step();
        check("reset1 kbd_ready", 16'(kbd_ready), 16'h0);
        step();
        check("reset2 inM", inM, 16'h0000);
        check("reset2 vid_data", vid_data, 16'h0000);
        drive(1'b0, 15'h6000, 16'h0000, 1'b0, 1'b0, 16'h0000, 13'h0000);
        step();
        check("post-reset kbd", inM, 16'h0000);
        check("post-reset screen kept", vid_data, 16'hFFFF);
        check("post-reset kbd_ready", 16'(kbd_ready), 16'h1);

        // Randomized traffic compared against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [14:0] a;
            logic [12:0] va;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 4)
                a = ($urandom_range(0, 1) == 0) ? 15'($urandom_range(0, 15))
                                                : 15'(16'h3FF0 + 16'($urandom_range(0, 15)));
            else if (sel < 7)
                a = ($urandom_range(0, 1) == 0) ? 15'(16'h4000 + 16'($urandom_range(0, 15)))
                                                : 15'(16'h5FF0 + 16'($urandom_range(0, 15)));
            else if (sel == 7)
                a = 15'h6000;
            else
                a = 15'($urandom_range(32'h6001, 32'h7FFF));
            va = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 15))
                                             : 13'(16'h1FF0 + 16'($urandom_range(0, 15)));
            drive(($urandom_range(0, 63) == 0), a, 16'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), 16'($urandom), va);
            step();
            if (e_inm_known) check("rand inM", inM, e_inm);
            if (e_vid_known) check("rand vid_data", vid_data, e_vid);
            check("rand bad_write", 16'(bad_write), 16'(m_bad));
            check("rand kbd_ready", 16'(kbd_ready), 16'(!reset));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
